pdm_filter_ctrl: RTL and testbench
==================================

Name: pdm_filter_ctrl

Overview:
- Sequences the PDM microphone front end and the CIC/decimation filter.
- Generates the PDM microphone clock from the system clock and samples the microphone data bit.
- Issues one-cycle data strobes to the filter and controls the filter's enable.
- Runs a power-up sequence (mic warm-up, then discard of initial filter outputs) before forwarding 8b samples downstream.

Parameters:
- CLK_DIV, 4, system clocks per PDM clock period; even, >= 2.
- WARMUP_CYCLES, 4000, PDM clock periods to wait after enable before the filter is enabled (mic startup); >= 1.
- DISCARD_SAMPLES, 2, filter output samples dropped after filter enable; >= 0.
- DATA_BW, 8, filter sample width.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- en_i  in  1  block enable; low returns to IDLE.
- pdm_data_i  in  1  microphone data bit.
- pdm_clk_o  out  1  microphone clock.
- filt_en_o  out  1  filter enable.
- filt_data_o  out  1  sampled PDM bit to filter.
- filt_valid_o  out  1  one-cycle strobe qualifying filt_data_o.
- filt_sample_i  in  DATA_BW  filter output sample (signed).
- filt_valid_i  in  1  filter output strobe.
- data_o  out  DATA_BW  forwarded sample (signed).
- valid_o  out  1  one-cycle strobe qualifying data_o.
- state_o  out  2  current state: IDLE=0, WARMUP=1, SETTLE=2, RUN=3.

Behaviour:
- Reset (rst_i=1 at posedge): state=IDLE; all counters=0. Outputs: pdm_clk_o=0, filt_en_o=0, filt_data_o=0, filt_valid_o=0, data_o=0, valid_o=0. Reset overrides en_i.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps.
  - Counts only in WARMUP/SETTLE/RUN; held at 0 in IDLE.
  - pdm_clk_o is registered; it is 1 while div_cnt < CLK_DIV/2, 0 otherwise, and forced 0 in IDLE.
- Sample point: the cycle where div_cnt==CLK_DIV-1 (end of low phase).
  - In SETTLE/RUN, pdm_data_i is registered into filt_data_o and filt_valid_o=1 on the following cycle.
  - filt_valid_o is never high in IDLE/WARMUP.
  - Strobe rate is exactly one per CLK_DIV cycles.
- IDLE:
  - en_i=1 -> WARMUP next cycle; div_cnt and warm_cnt start at 0.
- WARMUP:
  - filt_en_o=0.
  - warm_cnt increments at each div_cnt wrap.
  - At the wrap where warm_cnt==WARMUP_CYCLES-1: go to SETTLE if DISCARD_SAMPLES>0, else RUN.
- SETTLE:
  - filt_en_o=1 (registered, asserted the first cycle in SETTLE).
  - Each filt_valid_i pulse increments disc_cnt and is not forwarded.
  - The pulse that makes disc_cnt==DISCARD_SAMPLES moves to RUN next cycle; that pulse is also dropped.
- RUN:
  - filt_en_o=1.
  - On filt_valid_i=1, data_o<=filt_sample_i and valid_o=1 on the next cycle (latency 1).
  - data_o holds between strobes.
- Disable: en_i=0 in any non-IDLE state -> IDLE next cycle.
  - That cycle: pdm_clk_o=0, filt_en_o=0, filt_valid_o=0, valid_o=0; counters cleared.
  - A filt_valid_i in the same cycle en_i falls is dropped.
  - data_o retains its last value.
- Re-enable from IDLE always repeats the full WARMUP and SETTLE sequence.
- filt_valid_i outside SETTLE/RUN is ignored.
- Counters are sized clog2 of their limit and saturate-free; wrap cannot occur by construction.

Optional Feature:
- Macro: PDM_FILTER_CTRL_SAMPLE_CNT_EN.
- Defined:
  - Adds output port sample_cnt_o [15:0], counting valid_o pulses since the last IDLE exit.
  - Cleared by reset and in IDLE.
  - Wraps 0xFFFF -> 0x0000.
  - Updates in the same cycle valid_o is high.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_i=1 for 3 cycles with en_i=1 -> all outputs 0, state_o=0. Deassert -> state_o=1 one cycle later.
- Clock gen: CLK_DIV=4, en_i=1 -> pdm_clk_o pattern 1,1,0,0 repeating. filt_valid_o pulses every 4 cycles in RUN, with filt_data_o equal to pdm_data_i sampled at div_cnt=3.
- Warm-up: WARMUP_CYCLES=5, CLK_DIV=4 -> filt_en_o rises exactly 20 cycles after state_o becomes 1. No filt_valid_o before that.
- Discard: DISCARD_SAMPLES=2, drive filt_valid_i with samples 0x11, 0x22, 0x33, -5 -> only 0x33, then 0xFB appear on data_o, each with valid_o 1 cycle after its filt_valid_i. state_o=3 after the second pulse.
- DISCARD_SAMPLES=0 -> WARMUP goes directly to RUN; the first filt_valid_i is forwarded.
- Mid-run disable: en_i=0 in the same cycle as filt_valid_i -> no valid_o. Next cycle state_o=0, pdm_clk_o=0, filt_en_o=0. Re-enable -> full warm-up repeats.
- With PDM_FILTER_CTRL_SAMPLE_CNT_EN: 3 forwarded samples -> sample_cnt_o=3. Disable -> 0.

Source files
------------

// File: rtl/pdm_filter_ctrl.sv
// PDM front-end sequencer: mic clock generation, bit sampling, filter enable and sample forwarding.
// Latency: filter strobe 1 cycle after the sample point; forwarded sample 1 cycle after filt_valid_i.
// Backpressure: none; all strobes are fire-and-forget. Macro PDM_FILTER_CTRL_SAMPLE_CNT_EN adds sample_cnt_o.
module pdm_filter_ctrl #(
  parameter int CLK_DIV         = 4,
  parameter int WARMUP_CYCLES   = 4000,
  parameter int DISCARD_SAMPLES = 2,
  parameter int DATA_BW         = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               pdm_data_i,
  output logic               pdm_clk_o,
  output logic               filt_en_o,
  output logic               filt_data_o,
  output logic               filt_valid_o,
  input  logic [DATA_BW-1:0] filt_sample_i,
  input  logic               filt_valid_i,
  output logic [DATA_BW-1:0] data_o,
  output logic               valid_o,
`ifdef PDM_FILTER_CTRL_SAMPLE_CNT_EN
  output logic [15:0]        sample_cnt_o,
`endif
  output logic [1:0]         state_o
);

  localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WW        = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int SW        = (DISCARD_SAMPLES > 0) ? $clog2(DISCARD_SAMPLES + 1) : 1;
  localparam int DISC_LAST = (DISCARD_SAMPLES > 0) ? DISCARD_SAMPLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DW-1:0]      div_q, div_d;
  logic [WW-1:0]      warm_q, warm_d;
  logic [SW-1:0]      disc_q, disc_d;
  logic               pclk_q, pclk_d;
  logic               fen_q, fen_d;
  logic               fdat_q, fdat_d;
  logic               fval_q, fval_d;
  logic [DATA_BW-1:0] data_q, data_d;
  logic               val_q, val_d;
  logic               div_wrap;

  assign div_wrap = (div_q == DW'(CLK_DIV - 1));

  // Next-state, counter and output logic; the divider phase doubles as the sample point.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    warm_d  = warm_q;
    disc_d  = disc_q;
    fdat_d  = fdat_q;
    fval_d  = 1'b0;
    data_d  = data_q;
    val_d   = 1'b0;
    if (state_q == S_IDLE) begin
      div_d  = '0;
      warm_d = '0;
      disc_d = '0;
      if (en_i) state_d = S_WARMUP;
    end else if (!en_i) begin
      // Disable wins over everything, including a coincident filter strobe.
      state_d = S_IDLE;
      div_d   = '0;
      warm_d  = '0;
      disc_d  = '0;
    end else begin
      div_d = div_wrap ? '0 : div_q + 1'b1;
      if (state_q != S_WARMUP && div_wrap) begin
        fdat_d = pdm_data_i;
        fval_d = 1'b1;
      end
      case (state_q)
        S_WARMUP: begin
          if (div_wrap) begin
            if (warm_q == WW'(WARMUP_CYCLES - 1)) begin
              state_d = (DISCARD_SAMPLES > 0) ? S_SETTLE : S_RUN;
            end else begin
              warm_d = warm_q + 1'b1;
            end
          end
        end
        S_SETTLE: begin
          if (filt_valid_i) begin
            disc_d = disc_q + 1'b1;
            if (disc_q == SW'(DISC_LAST)) state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (filt_valid_i) begin
            data_d = filt_sample_i;
            val_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Mic clock tracks the divider phase of the cycle it is presented in.
    pclk_d = (state_d != S_IDLE) && (div_d < DW'(CLK_DIV / 2));
    fen_d  = (state_d == S_SETTLE) || (state_d == S_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      warm_q  <= '0;
      disc_q  <= '0;
      pclk_q  <= 1'b0;
      fen_q   <= 1'b0;
      fdat_q  <= 1'b0;
      fval_q  <= 1'b0;
      data_q  <= '0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      warm_q  <= warm_d;
      disc_q  <= disc_d;
      pclk_q  <= pclk_d;
      fen_q   <= fen_d;
      fdat_q  <= fdat_d;
      fval_q  <= fval_d;
      data_q  <= data_d;
      val_q   <= val_d;
    end
  end

`ifdef PDM_FILTER_CTRL_SAMPLE_CNT_EN
  logic [15:0] cnt_q;

  // Forwarded-sample counter; restarts from zero on every IDLE exit and wraps freely.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_d == S_IDLE) begin
      cnt_q <= '0;
    end else if (val_d) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign sample_cnt_o = cnt_q;
`endif

  assign pdm_clk_o    = pclk_q;
  assign filt_en_o    = fen_q;
  assign filt_data_o  = fdat_q;
  assign filt_valid_o = fval_q;
  assign data_o       = data_q;
  assign valid_o      = val_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_pdm_filter_ctrl.sv
// Bench for pdm_filter_ctrl: two instances (with and without a discard phase) share random stimulus.
// Expected values come from an elapsed-cycle model; forwarded samples go through a scoreboard queue.
// Optional sample counter is checked when PDM_FILTER_CTRL_SAMPLE_CNT_EN is defined.
module tb_pdm_filter_ctrl;

  localparam int D0 = 4, W0 = 5, S0 = 2;
  localparam int D1 = 6, W1 = 3, S1 = 0;

  typedef struct {
    int cyc;
    int dat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, pdm, fv;
  logic [7:0] fs;

  logic       pclk0, fen0, fdat0, fval0, val0;
  logic       pclk1, fen1, fdat1, fval1, val1;
  logic [7:0] dat0, dat1;
  logic [1:0] st0, st1;
  logic [15:0] cnt0, cnt1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state per instance: active flag, cycles since IDLE exit, pulses discarded so far.
  bit act [2];
  int k   [2];
  int nd  [2];
  int exp_st [2], exp_pclk [2], exp_fen [2], exp_fdat [2], exp_fval [2];
  int exp_val [2], exp_dat [2], exp_cnt [2];

  exp_t q0 [$];
  exp_t q1 [$];

  always #5 clk = ~clk;

  pdm_filter_ctrl #(.CLK_DIV(D0), .WARMUP_CYCLES(W0), .DISCARD_SAMPLES(S0), .DATA_BW(8)) dut0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .pdm_data_i(pdm),
    .pdm_clk_o(pclk0), .filt_en_o(fen0), .filt_data_o(fdat0), .filt_valid_o(fval0),
    .filt_sample_i(fs), .filt_valid_i(fv), .data_o(dat0), .valid_o(val0),
`ifdef PDM_FILTER_CTRL_SAMPLE_CNT_EN
    .sample_cnt_o(cnt0),
`endif
    .state_o(st0)
  );

  pdm_filter_ctrl #(.CLK_DIV(D1), .WARMUP_CYCLES(W1), .DISCARD_SAMPLES(S1), .DATA_BW(8)) dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .pdm_data_i(pdm),
    .pdm_clk_o(pclk1), .filt_en_o(fen1), .filt_data_o(fdat1), .filt_valid_o(fval1),
    .filt_sample_i(fs), .filt_valid_i(fv), .data_o(dat1), .valid_o(val1),
`ifdef PDM_FILTER_CTRL_SAMPLE_CNT_EN
    .sample_cnt_o(cnt1),
`endif
    .state_o(st1)
  );

`ifndef PDM_FILTER_CTRL_SAMPLE_CNT_EN
  assign cnt0 = 16'd0;
  assign cnt1 = 16'd0;
`endif

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act_v, exp_v);
    end
  endtask

  // Expected outputs after one clock edge, derived from time since enable and pulses seen.
  task automatic step(input int i, input int D, input int W, input int S,
                      output bit push, output int pd);
    int os, ns;
    push = 1'b0;
    pd   = 0;
    if (rst) begin
      act[i] = 1'b0;
      exp_st[i] = 0; exp_pclk[i] = 0; exp_fen[i] = 0; exp_fdat[i] = 0;
      exp_fval[i] = 0; exp_val[i] = 0; exp_dat[i] = 0; exp_cnt[i] = 0;
    end else if (!act[i]) begin
      exp_fval[i] = 0; exp_val[i] = 0; exp_cnt[i] = 0; exp_fen[i] = 0;
      if (en) begin
        act[i] = 1'b1; k[i] = 0; nd[i] = 0;
        exp_st[i] = 1; exp_pclk[i] = 1;
      end else begin
        exp_st[i] = 0; exp_pclk[i] = 0;
      end
    end else if (!en) begin
      act[i] = 1'b0;
      exp_st[i] = 0; exp_pclk[i] = 0; exp_fen[i] = 0;
      exp_fval[i] = 0; exp_val[i] = 0; exp_cnt[i] = 0;
    end else begin
      os = (k[i] < W * D) ? 1 : (nd[i] < S) ? 2 : 3;
      exp_fval[i] = (os >= 2 && (k[i] % D) == D - 1) ? 1 : 0;
      if (exp_fval[i] == 1) exp_fdat[i] = int'(pdm);
      exp_val[i] = 0;
      if (fv && os == 3) begin
        exp_val[i] = 1;
        exp_dat[i] = int'(fs);
        exp_cnt[i] = (exp_cnt[i] + 1) % 65536;
        push = 1'b1;
        pd   = int'(fs);
      end
      if (fv && os == 2) nd[i]++;
      k[i]++;
      ns = (k[i] < W * D) ? 1 : (nd[i] < S) ? 2 : 3;
      exp_st[i]   = ns;
      exp_pclk[i] = ((k[i] % D) < D / 2) ? 1 : 0;
      exp_fen[i]  = (ns >= 2) ? 1 : 0;
    end
  endtask

  // Reference model: advances on every clock edge and queues expected forwarded samples.
  initial begin
    bit p;
    int pd;
    forever begin
      @(posedge clk);
      cyc++;
      step(0, D0, W0, S0, p, pd);
      if (p) q0.push_back('{cyc, pd});
      step(1, D1, W1, S1, p, pd);
      if (p) q1.push_back('{cyc, pd});
    end
  end

  // Monitor: compares every output each cycle and drains the scoreboard on valid_o.
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("st0", 32'(st0), exp_st[0]);      chk("st1", 32'(st1), exp_st[1]);
      chk("pclk0", 32'(pclk0), exp_pclk[0]); chk("pclk1", 32'(pclk1), exp_pclk[1]);
      chk("fen0", 32'(fen0), exp_fen[0]);   chk("fen1", 32'(fen1), exp_fen[1]);
      chk("fval0", 32'(fval0), exp_fval[0]); chk("fval1", 32'(fval1), exp_fval[1]);
      chk("fdat0", 32'(fdat0), exp_fdat[0]); chk("fdat1", 32'(fdat1), exp_fdat[1]);
      chk("val0", 32'(val0), exp_val[0]);   chk("val1", 32'(val1), exp_val[1]);
      chk("dat0_hold", 32'(dat0), exp_dat[0]); chk("dat1_hold", 32'(dat1), exp_dat[1]);
`ifdef PDM_FILTER_CTRL_SAMPLE_CNT_EN
      chk("cnt0", 32'(cnt0), exp_cnt[0]);   chk("cnt1", 32'(cnt1), exp_cnt[1]);
`endif
      if (val0 === 1'b1) begin
        if (q0.size() == 0) chk("sb0_spurious", 32'(dat0), 32'hFFFF_FFFF);
        else begin
          e = q0.pop_front();
          chk("sb0_data", 32'(dat0), e.dat);
          chk("sb0_cycle", cyc, e.cyc);
        end
      end
      if (val1 === 1'b1) begin
        if (q1.size() == 0) chk("sb1_spurious", 32'(dat1), 32'hFFFF_FFFF);
        else begin
          e = q1.pop_front();
          chk("sb1_data", 32'(dat1), e.dat);
          chk("sb1_cycle", cyc, e.cyc);
        end
      end
      while (q0.size() > 0 && q0[0].cyc < cyc) begin
        e = q0.pop_front();
        chk("sb0_missing", 32'(cyc), e.cyc);
      end
      while (q1.size() > 0 && q1[0].cyc < cyc) begin
        e = q1.pop_front();
        chk("sb1_missing", 32'(cyc), e.cyc);
      end
    end
  end

  task automatic tick(input logic e_v, input logic v_v, input logic [7:0] s_v);
    en  = e_v;
    fv  = v_v;
    fs  = s_v;
    pdm = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  // Stimulus: reset, directed discard sequence, disable with coincident strobe, then random runs.
  initial begin
    rst = 1'b1; en = 1'b1; pdm = 1'b0; fv = 1'b0; fs = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (28) tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'h11); repeat (2) tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'h22); repeat (2) tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'h33); repeat (2) tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'hFB); repeat (2) tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'h44); tick(1'b1, 1'b1, 8'h80);
    tick(1'b0, 1'b1, 8'h5A);
    repeat (2) tick(1'b0, 1'b0, 8'h00);
    for (int r = 0; r < 24; r++) begin
      int on_len;
      on_len = $urandom_range(8, 160);
      for (int c = 0; c < on_len; c++)
        tick(1'b1, ($urandom_range(0, 3) == 0), 8'($urandom));
      if (r == 10) begin
        rst = 1'b1;
        repeat (2) tick(1'b1, 1'b1, 8'($urandom));
        rst = 1'b0;
      end else begin
        tick(1'b0, 1'b1, 8'($urandom));
        repeat ($urandom_range(0, 3)) tick(1'b0, ($urandom_range(0, 1) == 1), 8'($urandom));
      end
    end
    repeat (3) tick(1'b1, 1'b0, 8'h00);
    #2;
    chk("sb0_drain", 32'(q0.size()), 32'd0);
    chk("sb1_drain", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
